flag_xfer_arbiter: RTL and testbench

- clkA-domain arbiter that shares one flag/ack clock-domain-crossing channel between N_REQ requesters.
- Selects one pending requester round-robin and captures its payload and ID, held stable for the clkB side while the crossing is in flight.
- Issues a single-cycle flag into the crossing, tracks the crossing's busy signal through launch and acknowledge, then reports completion to the requester.
- Includes a watchdog that flags a stuck crossing.

---
 rtl/flag_xfer_arbiter.sv | 144 ++++++++++++++
 tb/tb_flag_xfer_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/flag_xfer_arbiter.sv
// Round-robin arbiter sharing one flag/ack clock-crossing channel between N_REQ
// requesters, with a sticky watchdog error for a crossing that never completes.
module flag_xfer_arbiter #(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = 8,
  parameter int ID_W        = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                    clkA,
  input  logic                    rstA,
  input  logic [N_REQ-1:0]        req_clkA,
  input  logic [N_REQ*DATA_W-1:0] data_clkA,
  output logic [N_REQ-1:0]        grant_clkA,
  output logic [N_REQ-1:0]        done_clkA,
  output logic                    flag_clkA,
  input  logic                    busy_clkA,
  output logic [DATA_W-1:0]       xfer_data_clkA,
  output logic [ID_W-1:0]         xfer_id_clkA,
  output logic                    active_clkA,
  output logic                    err_clkA,
  input  logic                    err_clr_clkA
);

  localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_ACK} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [N_REQ-1:0]  grant_q, grant_d, done_q, done_d;
  logic              flag_q, flag_d;
  logic [DATA_W-1:0] xdata_q, xdata_d;
  logic [ID_W-1:0]   xid_q, xid_d;
  logic              active_q, active_d;
  logic              err_q, err_d;

  logic              win_vld;
  logic [ID_W-1:0]   win_id;
  logic [ID_W-1:0]   nxt_ptr;
  logic              wd_hit;
  int                idx;

  // Scan upward from the pointer with wrap; first pending requester wins.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    idx     = 0;
    for (int off = 0; off < N_REQ; off++) begin
      idx = int'(ptr_q) + off;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!win_vld && req_clkA[idx]) begin
        win_vld = 1'b1;
        win_id  = ID_W'(idx);
      end
    end
  end

  assign nxt_ptr = (int'(xid_q) == N_REQ - 1) ? '0 : xid_q + ID_W'(1);
  assign wd_hit  = (TIMEOUT_CYC != 0) && (wd_q == WD_W'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    wd_d    = wd_q;
    grant_d = '0;
    done_d  = '0;
    flag_d  = 1'b0;
    xdata_d = xdata_q;
    xid_d   = xid_q;
    err_d   = err_q & ~err_clr_clkA;
    case (state_q)
      IDLE: begin
        wd_d = '0;
        if (win_vld) begin
          state_d         = LAUNCH;
          grant_d[win_id] = 1'b1;
          xid_d           = win_id;
          xdata_d         = data_clkA[int'(win_id)*DATA_W +: DATA_W];
        end
      end
      LAUNCH: begin
        wd_d = '0;
        // A busy left over from reset or a timeout must drain before relaunching.
        if (!busy_clkA) begin
          flag_d  = 1'b1;
          state_d = WAIT_BUSY;
        end
      end
      default: begin
        if (TIMEOUT_CYC != 0) wd_d = wd_q + WD_W'(1);
        if (wd_hit) begin
          err_d   = 1'b1;
          ptr_d   = nxt_ptr;
          wd_d    = '0;
          state_d = IDLE;
        end else if (state_q == WAIT_BUSY && busy_clkA) begin
          state_d = WAIT_ACK;
        end else if (state_q == WAIT_ACK && !busy_clkA) begin
          done_d[xid_q] = 1'b1;
          ptr_d         = nxt_ptr;
          wd_d          = '0;
          state_d       = IDLE;
        end
      end
    endcase
    active_d = (state_d != IDLE);
  end

  always_ff @(posedge clkA or posedge rstA) begin
    if (rstA) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      wd_q     <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      flag_q   <= 1'b0;
      xdata_q  <= '0;
      xid_q    <= '0;
      active_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      wd_q     <= wd_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      flag_q   <= flag_d;
      xdata_q  <= xdata_d;
      xid_q    <= xid_d;
      active_q <= active_d;
      err_q    <= err_d;
    end
  end

  assign grant_clkA     = grant_q;
  assign done_clkA      = done_q;
  assign flag_clkA      = flag_q;
  assign xfer_data_clkA = xdata_q;
  assign xfer_id_clkA   = xid_q;
  assign active_clkA    = active_q;
  assign err_clkA       = err_q;

endmodule

// File: tb/tb_flag_xfer_arbiter.sv
// Scoreboard bench for flag_xfer_arbiter: a simple crossing model answers each flag,
// and a monitor pops expected grants/dones as the DUT produces them.
module tb_flag_xfer_arbiter;

  logic        clkA, rstA;
  logic [3:0]  req_clkA;
  logic [31:0] data_clkA;
  logic [3:0]  grant_clkA, done_clkA;
  logic        flag_clkA, busy_clkA;
  logic [7:0]  xfer_data_clkA;
  logic [1:0]  xfer_id_clkA;
  logic        active_clkA, err_clkA, err_clr_clkA;

  logic xb_busy, force_busy, xb_en;
  assign busy_clkA = xb_busy | force_busy;

  flag_xfer_arbiter #(.N_REQ(4), .DATA_W(8), .ID_W(2), .TIMEOUT_CYC(16)) dut (
    .clkA(clkA), .rstA(rstA), .req_clkA(req_clkA), .data_clkA(data_clkA),
    .grant_clkA(grant_clkA), .done_clkA(done_clkA), .flag_clkA(flag_clkA),
    .busy_clkA(busy_clkA), .xfer_data_clkA(xfer_data_clkA), .xfer_id_clkA(xfer_id_clkA),
    .active_clkA(active_clkA), .err_clkA(err_clkA), .err_clr_clkA(err_clr_clkA)
  );

  typedef struct packed {
    logic [3:0] vec;
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  exp_t gq[$];
  int   dq[$];
  int   n_chk = 0, n_pass = 0;
  int   outst = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
  endtask

  task automatic expect_xfer(input int id, input logic [7:0] d, input bit with_done);
    exp_t e;
    e.vec  = 4'(1 << id);
    e.id   = 2'(id);
    e.data = d;
    gq.push_back(e);
    if (with_done) dq.push_back(id);
  endtask

  task automatic wait_sig(input string tag, input int which, input int bound, output int cyc);
    bit hit;
    cyc = 0;
    hit = 0;
    while (!hit && cyc < bound) begin
      @(negedge clkA);
      cyc++;
      case (which)
        0:       hit = flag_clkA;
        1:       hit = |done_clkA;
        default: hit = err_clkA;
      endcase
    end
    if (!hit) chk(tag, 0, 1);
  endtask

  task automatic drain(input string tag, input int bound);
    int n;
    n = 0;
    while ((gq.size() != 0 || dq.size() != 0) && n < bound) begin
      @(negedge clkA);
      n++;
    end
    chk(tag, gq.size() + dq.size(), 0);
  endtask

  initial begin
    clkA = 0;
    forever #5 clkA = ~clkA;
  end

  // Crossing model: busy rises one cycle after the flag and stays high for 6 cycles.
  initial begin
    xb_busy = 0;
    forever begin
      @(negedge clkA);
      if (flag_clkA && xb_en) begin
        @(negedge clkA);
        xb_busy = 1;
        repeat (6) @(negedge clkA);
        xb_busy = 0;
      end
    end
  end

  // Monitor: every grant/done must match the head of its expected queue.
  initial begin
    exp_t em;
    int   did;
    logic err_prev;
    err_prev = 0;
    forever begin
      @(negedge clkA);
      if (rstA || (err_clkA && !err_prev)) outst = 0;
      err_prev = err_clkA;
      if (grant_clkA != 0) begin
        if (gq.size() == 0) chk("grant_unexpected", 32'(grant_clkA), 0);
        else begin
          em = gq.pop_front();
          chk("grant_vec", 32'(grant_clkA), 32'(em.vec));
          chk("grant_id", 32'(xfer_id_clkA), 32'(em.id));
          chk("grant_data", 32'(xfer_data_clkA), 32'(em.data));
          chk("grant_overlap", outst, 0);
        end
        outst = 1;
      end
      if (done_clkA != 0) begin
        if (dq.size() == 0) chk("done_unexpected", 32'(done_clkA), 0);
        else begin
          did = dq.pop_front();
          chk("done_vec", 32'(done_clkA), 32'(1 << did));
        end
        outst = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck want finish");
    $fatal(1);
  end

  initial begin
    int g, n, cyc;
    bit fl_seen;
    rstA = 1; req_clkA = 0; data_clkA = 0; err_clr_clkA = 0;
    force_busy = 0; xb_en = 1;
    #12;
    chk("reset_outs", {11'd0, grant_clkA, done_clkA, flag_clkA, xfer_data_clkA,
                       xfer_id_clkA, active_clkA, err_clkA}, 0);
    @(negedge clkA);
    rstA = 0;
    @(negedge clkA);

    // Fairness: all four held, pointer starts at 0.
    data_clkA = 32'h43322110;
    req_clkA  = 4'b1111;
    expect_xfer(0, 8'h10, 1); expect_xfer(1, 8'h21, 1); expect_xfer(2, 8'h32, 1);
    expect_xfer(3, 8'h43, 1); expect_xfer(0, 8'h10, 1);
    g = 0; n = 0;
    while (g < 5 && n < 300) begin
      @(negedge clkA);
      n++;
      if (grant_clkA != 0) g++;
    end
    req_clkA = 0;
    chk("fair_grants", g, 5);
    drain("fair_drain", 100);

    // Single request, latency and stability.
    @(negedge clkA);
    data_clkA[15:8] = 8'hA5;
    req_clkA = 4'b0010;
    expect_xfer(1, 8'hA5, 1);
    @(negedge clkA);
    chk("single_grant", 32'(grant_clkA), 32'h2);
    chk("single_active", 32'(active_clkA), 1);
    req_clkA = 0;
    @(negedge clkA);
    chk("single_flag", 32'(flag_clkA), 1);
    wait_sig("single_done_wait", 1, 40, cyc);
    chk("single_done_lat", cyc, 8);
    chk("single_stable", {xfer_id_clkA, xfer_data_clkA}, {2'd1, 8'hA5});
    drain("single_drain", 10);

    // Busy already high entering LAUNCH: flag held off until it drops.
    @(negedge clkA);
    force_busy = 1;
    data_clkA[31:24] = 8'h77;
    req_clkA = 4'b1000;
    expect_xfer(3, 8'h77, 1);
    @(negedge clkA);
    chk("lnch_grant", 32'(grant_clkA), 32'h8);
    req_clkA = 0;
    fl_seen = 0;
    repeat (5) begin
      @(negedge clkA);
      fl_seen |= flag_clkA;
    end
    chk("lnch_hold", 32'(fl_seen), 0);
    force_busy = 0;
    @(negedge clkA);
    chk("lnch_flag", 32'(flag_clkA), 1);
    drain("lnch_drain", 40);

    // Watchdog: crossing never answers.
    @(negedge clkA);
    xb_en = 0;
    data_clkA[7:0] = 8'h5A;
    req_clkA = 4'b0001;
    expect_xfer(0, 8'h5A, 0);
    @(negedge clkA);
    req_clkA = 0;
    wait_sig("wd_flag_wait", 0, 5, cyc);
    wait_sig("wd_err_wait", 2, 40, cyc);
    chk("wd_latency", cyc, 16);
    chk("wd_idle", 32'(active_clkA), 0);
    xb_en = 1;
    data_clkA[15:8] = 8'h66;
    req_clkA = 4'b0011;
    expect_xfer(1, 8'h66, 1);
    @(negedge clkA);
    chk("wd_next_grant", 32'(grant_clkA), 32'h2);
    req_clkA = 0;
    drain("wd_drain", 40);
    chk("err_sticky", 32'(err_clkA), 1);
    err_clr_clkA = 1;
    @(negedge clkA);
    err_clr_clkA = 0;
    chk("err_clear", 32'(err_clkA), 0);

    // Request dropped after grant; payload must not follow the input.
    @(negedge clkA);
    data_clkA[7:0] = 8'h3C;
    req_clkA = 4'b0001;
    expect_xfer(0, 8'h3C, 1);
    @(negedge clkA);
    req_clkA = 0;
    data_clkA[7:0] = 8'hFF;
    wait_sig("drop_done_wait", 1, 40, cyc);
    chk("drop_payload", 32'(xfer_data_clkA), 32'h3C);
    drain("drop_drain", 10);

    // Async reset while waiting for the ack.
    @(negedge clkA);
    data_clkA[15:8] = 8'h99;
    req_clkA = 4'b0010;
    expect_xfer(1, 8'h99, 0);
    @(negedge clkA);
    req_clkA = 0;
    wait_sig("rst_flag_wait", 0, 5, cyc);
    repeat (3) @(negedge clkA);
    chk("rst_in_wait", 32'(active_clkA), 1);
    #2 rstA = 1;
    #1;
    chk("rst_async_outs", {11'd0, grant_clkA, done_clkA, flag_clkA, xfer_data_clkA,
                           xfer_id_clkA, active_clkA, err_clkA}, 0);
    n = 0;
    while (xb_busy && n < 20) begin
      @(negedge clkA);
      n++;
    end
    @(negedge clkA);
    rstA = 0;
    data_clkA[23:16] = 8'hC3;
    req_clkA = 4'b0100;
    expect_xfer(2, 8'hC3, 1);
    @(negedge clkA);
    chk("rst_regrant", 32'(grant_clkA), 32'h4);
    req_clkA = 0;
    drain("rst_drain", 40);

    repeat (5) @(negedge clkA);
    chk("sb_empty", gq.size() + dq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
